// File: rtl/miner_job_master.sv
// Bus initiator that loads a mining job into the miner register map, polls status and returns the nonce.
// Optional poll timeout is built only when MINER_POLL_TIMEOUT_EN is defined.
module miner_job_master #(
    parameter int unsigned POLL_GAP       = 0,
    parameter logic [31:0] STATUS_FOUND   = 32'h3,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic         job_load_target,
    input  logic         job_load_msg,
    input  logic [255:0] job_target,
    input  logic [607:0] job_msg,
    output logic [4:0]   masterAddr,
    output logic [31:0]  masterWriteData,
    output logic         masterWrite,
    output logic         masterRead,
    output logic         masterChipSelect,
    input  logic [31:0]  masterReadData,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic         result_timeout
);

    typedef enum logic [3:0] {
        StIdle, StTgtWr, StTgtGo, StTgtClr, StMsgWr, StMsgGo, StMsgClr,
        StPollRd, StPollChk, StPollGap, StNonceRd, StNonceChk, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   gap_q, gap_d;
    logic          load_msg_q, load_msg_d;
    logic [255:0]  tgt_q, tgt_d;
    logic [607:0]  msg_q, msg_d;
    logic [31:0]   nonce_q, nonce_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
`ifdef MINER_POLL_TIMEOUT_EN
    logic [31:0]   to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        load_msg_d = load_msg_q;
        tgt_d      = tgt_q;
        msg_d      = msg_q;
        nonce_d    = nonce_q;
        valid_d    = valid_q;
`ifdef MINER_POLL_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (job_valid && ready_q) begin
                    tgt_d      = job_target;
                    msg_d      = job_msg;
                    load_msg_d = job_load_msg;
                    cnt_d      = job_load_target ? 5'd7 : 5'd0;
                    if (job_load_target)   state_d = StTgtWr;
                    else if (job_load_msg) state_d = StMsgWr;
                    else                   state_d = StMsgGo;
                end
            end
            StTgtWr: begin
                if (cnt_q == 5'd0) state_d = StTgtGo;
                else               cnt_d = cnt_q - 5'd1;
            end
            StTgtGo:  state_d = StTgtClr;
            StTgtClr: begin
                cnt_d   = 5'd0;
                state_d = load_msg_q ? StMsgWr : StMsgGo;
            end
            StMsgWr: begin
                if (cnt_q == 5'd18) state_d = StMsgGo;
                else                cnt_d = cnt_q + 5'd1;
            end
            StMsgGo:  state_d = StMsgClr;
            StMsgClr: begin
                state_d = StPollRd;
`ifdef MINER_POLL_TIMEOUT_EN
                to_cnt_d = 32'd0;
`endif
            end
            StPollRd: state_d = StPollChk;
            StPollChk: begin
                gap_d = 32'd0;
                if (masterReadData == STATUS_FOUND) state_d = StNonceRd;
                else if (POLL_GAP == 0)             state_d = StPollRd;
                else                                state_d = StPollGap;
            end
            StPollGap: begin
                if (gap_q + 32'd1 >= POLL_GAP) state_d = StPollRd;
                else                           gap_d = gap_q + 32'd1;
            end
            StNonceRd: state_d = StNonceChk;
            StNonceChk: begin
                nonce_d = masterReadData;
                valid_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (result_ready) begin
                    valid_d = 1'b0;
`ifdef MINER_POLL_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef MINER_POLL_TIMEOUT_EN
        // Timeout overrides whatever the poll states decided this cycle.
        if (state_q == StPollRd || state_q == StPollChk || state_q == StPollGap) begin
            to_cnt_d = to_cnt_q + 32'd1;
            if (to_cnt_d >= TIMEOUT_CYCLES) begin
                state_d   = StDone;
                valid_d   = 1'b1;
                timeout_d = 1'b1;
                nonce_d   = 32'd0;
            end
        end
`endif

        // Bus outputs are registered: decode the access of the state being entered.
        write_d = 1'b0;
        read_d  = 1'b0;
        addr_d  = 5'd0;
        wdata_d = 32'd0;
        case (state_d)
            StTgtWr: begin
                write_d = 1'b1;
                addr_d  = cnt_d + 5'd2;
                wdata_d = tgt_d[{cnt_d[2:0], 5'd0} +: 32];
            end
            StTgtGo:  begin write_d = 1'b1; addr_d = 5'd1; wdata_d = 32'd1; end
            StTgtClr: begin write_d = 1'b1; addr_d = 5'd1; end
            StMsgWr: begin
                write_d = 1'b1;
                addr_d  = 5'd29 - cnt_d;
                wdata_d = msg_d[{5'd18 - cnt_d, 5'd0} +: 32];
            end
            StMsgGo:   begin write_d = 1'b1; addr_d = 5'd1; wdata_d = 32'd2; end
            StMsgClr:  begin write_d = 1'b1; addr_d = 5'd1; end
            StPollRd:  read_d = 1'b1;
            StNonceRd: begin read_d = 1'b1; addr_d = 5'd10; end
            default: ;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            gap_q      <= 32'd0;
            load_msg_q <= 1'b0;
            nonce_q    <= 32'd0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            addr_q     <= 5'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
`ifdef MINER_POLL_TIMEOUT_EN
            to_cnt_q   <= 32'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            load_msg_q <= load_msg_d;
            nonce_q    <= nonce_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            read_q     <= read_d;
`ifdef MINER_POLL_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
        msg_q <= msg_d;
    end

    assign job_ready        = ready_q;
    assign masterAddr       = addr_q;
    assign masterWriteData  = wdata_q;
    assign masterWrite      = write_q;
    assign masterRead       = read_q;
    assign masterChipSelect = write_q | read_q;
    assign result_valid     = valid_q;
    assign result_nonce     = nonce_q;
`ifdef MINER_POLL_TIMEOUT_EN
    assign result_timeout   = timeout_q;
`else
    // No timeout counter in this build; the flag is a constant zero.
    assign result_timeout   = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_miner_job_master.sv
// Directed bench for miner_job_master: register write order, polling cadence, result handshake, reset.
// A small bus model answers status/nonce reads; define MINER_POLL_TIMEOUT_EN to add the timeout case.
module tb_miner_job_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic         job_load_target = 1'b0;
    logic         job_load_msg = 1'b0;
    logic [255:0] job_target = '0;
    logic [607:0] job_msg = '0;
    logic [4:0]   masterAddr;
    logic [31:0]  masterWriteData;
    logic         masterWrite;
    logic         masterRead;
    logic         masterChipSelect;
    logic [31:0]  masterReadData = 32'd0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [31:0]  result_nonce;
    logic         result_timeout;

    always #5 clk = ~clk;

    miner_job_master #(
        .POLL_GAP       (3),
        .STATUS_FOUND   (32'h3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_load_target  (job_load_target),
        .job_load_msg     (job_load_msg),
        .job_target       (job_target),
        .job_msg          (job_msg),
        .masterAddr       (masterAddr),
        .masterWriteData  (masterWriteData),
        .masterWrite      (masterWrite),
        .masterRead       (masterRead),
        .masterChipSelect (masterChipSelect),
        .masterReadData   (masterReadData),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_nonce     (result_nonce),
        .result_timeout   (result_timeout)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          polls = 0;
    int          poll_base = 0;
    int          found_at = 0;
    logic [31:0] nonce_val = 32'd0;
    int          cs_bad = 0;
    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [4:0]  rd_addr[$];
    int          rd_cyc[$];
    int          hs, bw, br;

    // Bus slave model: logs every access and answers reads one cycle later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (masterChipSelect !== (masterWrite | masterRead)) cs_bad <= cs_bad + 1;
        if (masterWrite === 1'b1) begin
            wr_addr.push_back(masterAddr);
            wr_data.push_back(masterWriteData);
            wr_cyc.push_back(cyc);
        end
        if (masterRead === 1'b1) begin
            rd_addr.push_back(masterAddr);
            rd_cyc.push_back(cyc);
            if (masterAddr == 5'd0) begin
                polls <= polls + 1;
                masterReadData <= (polls + 1 - poll_base == found_at) ? 32'h3 : 32'h1;
            end else begin
                masterReadData <= nonce_val;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_job(input logic [255:0] t, input logic [607:0] m, input logic lt,
                            input logic lm);
        int n = 0;
        @(negedge clk);
        while (job_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("job_ready before handshake", {63'd0, job_ready}, 64'd1);
        bw = wr_addr.size();
        br = rd_addr.size();
        poll_base = polls;
        job_target = t;
        job_msg = m;
        job_load_target = lt;
        job_load_msg = lm;
        job_valid = 1'b1;
        hs = cyc;
        @(negedge clk);
        // Inputs must be ignored after the handshake.
        job_valid = 1'b0;
        job_target = ~t;
        job_msg = ~m;
        job_load_target = ~lt;
        job_load_msg = ~lm;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (result_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check({tag, " result_valid"}, {63'd0, result_valid}, 64'd1);
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, " valid drops"}, {63'd0, result_valid}, 64'd0);
        check({tag, " job_ready back"}, {63'd0, job_ready}, 64'd1);
    endtask

    logic [255:0] tgt1, tgt5;
    logic [607:0] msg1;
    logic [31:0]  w1[19];
    logic [4:0]   ex_a[$];
    logic [31:0]  ex_d[$];
    int           n, nw;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst job_ready", {63'd0, job_ready}, 64'd0);
        check("rst masterWrite", {63'd0, masterWrite}, 64'd0);
        check("rst masterRead", {63'd0, masterRead}, 64'd0);
        check("rst chipselect", {63'd0, masterChipSelect}, 64'd0);
        check("rst addr", {59'd0, masterAddr}, 64'd0);
        check("rst wdata", {32'd0, masterWriteData}, 64'd0);
        check("rst result_valid", {63'd0, result_valid}, 64'd0);
        check("rst result_nonce", {32'd0, result_nonce}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("job_ready after rst", {63'd0, job_ready}, 64'd1);

        // Job 1: target and message, found on 5th poll, nonce 42
        tgt1 = {32'h10000000, 224'd0};
        msg1 = '0;
        for (int k = 0; k < 19; k++) begin
            w1[k] = (k == 0) ? 32'h00400000 : (k == 1) ? 32'he3b0c442 :
                    (k == 18) ? 32'h1d00ffff : {4{8'(k)}};
            msg1[32*(18-k) +: 32] = w1[k];
        end
        for (int i = 0; i < 8; i++) begin
            ex_a.push_back(5'(9 - i));
            ex_d.push_back(i == 0 ? 32'h10000000 : 32'd0);
        end
        ex_a.push_back(5'd1); ex_d.push_back(32'd1);
        ex_a.push_back(5'd1); ex_d.push_back(32'd0);
        for (int k = 0; k < 19; k++) begin ex_a.push_back(5'(29 - k)); ex_d.push_back(w1[k]); end
        ex_a.push_back(5'd1); ex_d.push_back(32'd2);
        ex_a.push_back(5'd1); ex_d.push_back(32'd0);
        found_at = 5;
        nonce_val = 32'd42;
        send_job(tgt1, msg1, 1'b1, 1'b1);
        wait_valid("j1");
        check("j1 result cycle", 64'(cyc), 64'(hs + 56));
        check("j1 nonce", {32'd0, result_nonce}, 64'd42);
        check("j1 timeout flag", {63'd0, result_timeout}, 64'd0);
        check("j1 write count", 64'(wr_addr.size() - bw), 64'd31);
        for (int i = 0; i < 31; i++) begin
            check($sformatf("j1 wr%0d addr", i), {59'd0, wr_addr[bw+i]}, {59'd0, ex_a[i]});
            check($sformatf("j1 wr%0d data", i), {32'd0, wr_data[bw+i]}, {32'd0, ex_d[i]});
            check($sformatf("j1 wr%0d cycle", i), 64'(wr_cyc[bw+i]), 64'(hs + 1 + i));
        end
        check("j1 first data", {32'd0, wr_data[bw]}, 64'h10000000);
        check("j1 addr11 data", {32'd0, wr_data[bw+28]}, 64'h1d00ffff);
        check("j1 poll count", 64'(polls - poll_base), 64'd5);
        check("j1 read count", 64'(rd_addr.size() - br), 64'd6);
        check("j1 first poll cycle", 64'(rd_cyc[br]), 64'(hs + 32));
        check("j1 nonce read addr", {59'd0, rd_addr[br+5]}, 64'd10);
        accept("j1");

        // Job 2: message "a" only
        found_at = 1;
        nonce_val = 32'd12;
        send_job(256'd0, 608'h61, 1'b0, 1'b1);
        wait_valid("j2");
        check("j2 nonce", {32'd0, result_nonce}, 64'd12);
        check("j2 write count", 64'(wr_addr.size() - bw), 64'd21);
        nw = 0;
        for (int i = bw; i < wr_addr.size(); i++)
            if (wr_addr[i] >= 5'd2 && wr_addr[i] <= 5'd9) nw++;
        check("j2 target writes", 64'(nw), 64'd0);
        check("j2 first addr", {59'd0, wr_addr[bw]}, 64'd29);
        check("j2 first cycle", 64'(wr_cyc[bw]), 64'(hs + 1));
        check("j2 addr11", {59'd0, wr_addr[bw+18]}, 64'd11);
        check("j2 addr11 data", {32'd0, wr_data[bw+18]}, 64'h61);
        accept("j2");

        // Job 3: retrigger only, result_ready held high throughout
        found_at = 2;
        result_ready = 1'b1;
        send_job(256'd0, 608'd0, 1'b0, 1'b0);
        result_ready = 1'b1;
        wait_valid("j3");
        check("j3 nonce", {32'd0, result_nonce}, 64'd12);
        check("j3 write count", 64'(wr_addr.size() - bw), 64'd2);
        check("j3 wr0", {27'd0, wr_addr[bw], wr_data[bw]}, {27'd0, 5'd1, 32'd2});
        check("j3 wr1", {27'd0, wr_addr[bw+1], wr_data[bw+1]}, {27'd0, 5'd1, 32'd0});
        check("j3 wr0 cycle", 64'(wr_cyc[bw]), 64'(hs + 1));
        @(negedge clk);
        result_ready = 1'b0;
        check("j3 valid one cycle", {63'd0, result_valid}, 64'd0);
        check("j3 job_ready", {63'd0, job_ready}, 64'd1);

        // Job 4: ten failing polls, 5-cycle poll spacing, result held under backpressure
        found_at = 11;
        nonce_val = 32'hdeadbeef;
        send_job(256'd0, 608'd0, 1'b0, 1'b0);
        wait_valid("j4");
        check("j4 read count", 64'(rd_addr.size() - br), 64'd12);
        for (int i = 0; i < 10; i++)
            check($sformatf("j4 poll gap %0d", i), 64'(rd_cyc[br+i+1] - rd_cyc[br+i]), 64'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("j4 hold valid %0d", i), {63'd0, result_valid}, 64'd1);
            check($sformatf("j4 hold nonce %0d", i), {32'd0, result_nonce}, 64'hdeadbeef);
            check($sformatf("j4 hold job_ready %0d", i), {63'd0, job_ready}, 64'd0);
        end
        accept("j4");

        // Reset during the 10th message write, then a fresh job restarts from addr 9
        found_at = 1;
        nonce_val = 32'd7;
        tgt5 = {32'hcafef00d, 224'h1};
        send_job(tgt5, msg1, 1'b1, 1'b1);
        n = 0;
        while (!(masterWrite === 1'b1 && masterAddr === 5'd20) && n < 100) begin
            @(negedge clk); n++;
        end
        check("j5 reached 10th msg write", {59'd0, masterAddr}, 64'd20);
        rst = 1'b1;
        @(negedge clk);
        check("j5 write dropped", {63'd0, masterWrite}, 64'd0);
        check("j5 read dropped", {63'd0, masterRead}, 64'd0);
        check("j5 cs dropped", {63'd0, masterChipSelect}, 64'd0);
        check("j5 job_ready in rst", {63'd0, job_ready}, 64'd0);
        nw = wr_addr.size();
        rst = 1'b0;
        @(negedge clk);
        check("j5 job_ready after rst", {63'd0, job_ready}, 64'd1);
        repeat (3) @(negedge clk);
        check("j5 no recovery writes", 64'(wr_addr.size()), 64'(nw));
        send_job(tgt5, msg1, 1'b1, 1'b1);
        wait_valid("j5b");
        check("j5b first addr", {59'd0, wr_addr[bw]}, 64'd9);
        check("j5b first data", {32'd0, wr_data[bw]}, 64'hcafef00d);
        check("j5b last target data", {32'd0, wr_data[bw+7]}, 64'h1);
        check("j5b nonce", {32'd0, result_nonce}, 64'd7);
        accept("j5b");

`ifdef MINER_POLL_TIMEOUT_EN
        // Status never found: timeout result with zero nonce and no nonce read
        found_at = 0;
        send_job(256'd0, 608'd0, 1'b0, 1'b0);
        wait_valid("to");
        check("to timeout flag", {63'd0, result_timeout}, 64'd1);
        check("to nonce", {32'd0, result_nonce}, 64'd0);
        nw = 0;
        for (int i = br; i < rd_addr.size(); i++) if (rd_addr[i] == 5'd10) nw++;
        check("to nonce reads", 64'(nw), 64'd0);
        accept("to");
`endif

        check("chip select tracks strobes", 64'(cs_bad), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
